// File: rtl/spixel_pkg.sv
// Shared types for the superpixel animator: FSM state encoding, sprite
// position record and the per-sprite power-on position.
// Position fields are POS_W wide; users keep X_W and Y_W at or below POS_W.
package spixel_pkg;

    localparam int POS_W = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ERASE_REQ  = 3'd1,
        ERASE_WAIT = 3'd2,
        DRAW_REQ   = 3'd3,
        DRAW_WAIT  = 3'd4,
        FRAME_END  = 3'd5
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } pos_t;

    // Sprite k starts on row 0, column k, so sprites never begin stacked.
    function automatic pos_t reset_pos(input int k);
        pos_t p;
        p.x = POS_W'(k);
        p.y = '0;
        return p;
    endfunction

endpackage

// File: rtl/spixel_stepper.sv
// Next-position calculator for one sprite (purely combinational).
// Ports: cur -> nxt; with SPIXEL_ANIMATOR_BOUNCE_EN also dx/dy -> ndx/ndy.
// Direction bits: 0 = +1, 1 = -1. Without the macro the sprite rasters.
module spixel_stepper
    import spixel_pkg::*;
#(
    parameter int X_MAX = 31,
    parameter int Y_MAX = 23
) (
    input  pos_t cur,
    output pos_t nxt
`ifdef SPIXEL_ANIMATOR_BOUNCE_EN
    ,
    input  logic dx,
    input  logic dy,
    output logic ndx,
    output logic ndy
`endif
);

`ifdef SPIXEL_ANIMATOR_BOUNCE_EN
    // At an edge the direction is turned to point back into the field before
    // the step is taken, so a sprite never leaves the visible area.
    always_comb begin
        ndx = dx;
        ndy = dy;
        if (cur.x == '0)
            ndx = 1'b0;
        else if (cur.x == POS_W'(X_MAX))
            ndx = 1'b1;
        if (cur.y == '0)
            ndy = 1'b0;
        else if (cur.y == POS_W'(Y_MAX))
            ndy = 1'b1;
        nxt.x = ndx ? cur.x - POS_W'(1) : cur.x + POS_W'(1);
        nxt.y = ndy ? cur.y - POS_W'(1) : cur.y + POS_W'(1);
    end
`else
    always_comb begin
        nxt = cur;
        if (cur.x == POS_W'(X_MAX)) begin
            nxt.x = '0;
            nxt.y = (cur.y == POS_W'(Y_MAX)) ? '0 : cur.y + POS_W'(1);
        end else begin
            nxt.x = cur.x + POS_W'(1);
        end
    end
`endif

endmodule

// File: rtl/spixel_animator.sv
// Superpixel animator: every accepted tick erases all sprites at their old
// positions, then draws all at new positions through a one-at-a-time draw port.
// Ports: clk/rst (sync, active-high), ienable, icolor -> ox/oy/ocolor/ovld,
// idone handshake, obusy, oframe_done, sticky oovr. Macro: SPIXEL_ANIMATOR_BOUNCE_EN.
module spixel_animator
    import spixel_pkg::*;
#(
    parameter int N_SPR    = 4,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int X_MAX    = 31,
    parameter int Y_MAX    = 23,
    parameter int COLOR_W  = 8,
    parameter int TICK_MAX = 24999999,
    parameter logic [COLOR_W-1:0] BG_COLOR = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ienable,
    input  logic [N_SPR*COLOR_W-1:0] icolor,
    output logic [X_W-1:0]           ox,
    output logic [Y_W-1:0]           oy,
    output logic [COLOR_W-1:0]       ocolor,
    output logic                     ovld,
    input  logic                     idone,
    output logic                     obusy,
    output logic                     oframe_done,
    output logic                     oovr
);

    localparam int K_W   = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int CNT_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

    state_t             state, state_nxt;
    logic [K_W-1:0]     k;
    logic [CNT_W-1:0]   cnt;
    logic               tick, accept, last_k, ack;
    logic [COLOR_W-1:0] col_q, col_k;

    pos_t cur_pos [N_SPR];
    pos_t old_pos [N_SPR];
    pos_t nxt_pos [N_SPR];

    assign tick   = (cnt == CNT_W'(TICK_MAX));
    assign accept = (state == IDLE) && tick && ienable;
    assign last_k = (k == K_W'(N_SPR - 1));
    assign ack    = idone && ((state == ERASE_WAIT) || (state == DRAW_WAIT));
    assign col_k  = icolor[int'(k)*COLOR_W +: COLOR_W];

    always_ff @(posedge clk) begin
        if (rst || tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (accept) state_nxt = ERASE_REQ;
            ERASE_REQ:  state_nxt = ERASE_WAIT;
            ERASE_WAIT: if (idone) state_nxt = last_k ? DRAW_REQ : ERASE_REQ;
            DRAW_REQ:   state_nxt = DRAW_WAIT;
            DRAW_WAIT:  if (idone) state_nxt = last_k ? FRAME_END : DRAW_REQ;
            FRAME_END:  state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. Coordinates come from registers that only move in IDLE,
    // and the draw colour is captured at DRAW_REQ, so the request holds
    // steady until idone even if icolor changes meanwhile.
    always_comb begin
        ovld        = (state == ERASE_REQ) || (state == DRAW_REQ);
        obusy       = (state != IDLE);
        oframe_done = (state == FRAME_END);
        ox          = '0;
        oy          = '0;
        ocolor      = '0;
        case (state)
            ERASE_REQ, ERASE_WAIT: begin
                ox     = old_pos[k].x[X_W-1:0];
                oy     = old_pos[k].y[Y_W-1:0];
                ocolor = BG_COLOR;
            end
            DRAW_REQ: begin
                ox     = cur_pos[k].x[X_W-1:0];
                oy     = cur_pos[k].y[Y_W-1:0];
                ocolor = col_k;
            end
            DRAW_WAIT: begin
                ox     = cur_pos[k].x[X_W-1:0];
                oy     = cur_pos[k].y[Y_W-1:0];
                ocolor = col_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k     <= '0;
            oovr  <= 1'b0;
            col_q <= '0;
        end else begin
            if (accept)
                k <= '0;
            else if (ack)
                k <= last_k ? '0 : k + K_W'(1);
            // A tick that finds the frame still in flight is lost.
            if (tick && ienable && (state != IDLE))
                oovr <= 1'b1;
            if (state == DRAW_REQ)
                col_q <= col_k;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SPR; i++) begin
            if (rst) begin
                cur_pos[i] <= reset_pos(i);
                old_pos[i] <= reset_pos(i);
            end else if (accept) begin
                old_pos[i] <= cur_pos[i];
                cur_pos[i] <= nxt_pos[i];
            end
        end
    end

`ifdef SPIXEL_ANIMATOR_BOUNCE_EN
    logic [N_SPR-1:0] dx, dy, ndx, ndy;

    always_ff @(posedge clk) begin
        if (rst) begin
            dx <= '0;
            dy <= '0;
        end else if (accept) begin
            dx <= ndx;
            dy <= ndy;
        end
    end
`endif

    for (genvar g = 0; g < N_SPR; g++) begin : g_step
        spixel_stepper #(
            .X_MAX(X_MAX),
            .Y_MAX(Y_MAX)
        ) u_step (
            .cur(cur_pos[g]),
            .nxt(nxt_pos[g])
`ifdef SPIXEL_ANIMATOR_BOUNCE_EN
            ,
            .dx (dx[g]),
            .dy (dy[g]),
            .ndx(ndx[g]),
            .ndy(ndy[g])
`endif
        );
    end

endmodule

// File: doc/spixel_animator.md
SPIXEL_ANIMATOR -- requirements
Module: spixel_animator

Interface
REQ-001 The module SHALL have parameter N_SPR, default 4, giving the number of superpixel sprites (1..8).
REQ-002 The module SHALL have parameter X_W, default 5, giving the logical x width.
REQ-003 The module SHALL have parameter Y_W, default 5, giving the logical y width.
REQ-004 The module SHALL have parameter X_MAX, default 31, giving the last logical column.
REQ-005 The module SHALL have parameter Y_MAX, default 23, giving the last logical row.
REQ-006 The module SHALL have parameter COLOR_W, default 8, giving the colour-ID width.
REQ-007 The module SHALL have parameter TICK_MAX, default 24999999, giving the step period of TICK_MAX+1 clk cycles.
REQ-008 The module SHALL have parameter BG_COLOR, default 8'hFF, giving the erase colour.
REQ-009 The module SHALL have port clk, input, 1 bit: the clock.
REQ-010 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-011 The module SHALL have port ienable, input, 1 bit: gates position stepping.
REQ-012 The module SHALL have port icolor, input, N_SPR*COLOR_W bits: sprite k colour in slice k.
REQ-013 The module SHALL have ports ox (output, X_W) and oy (output, Y_W): draw request coordinate.
REQ-014 The module SHALL have port ocolor, output, COLOR_W: draw request colour.
REQ-015 The module SHALL have port ovld, output, 1 bit: one-cycle draw request pulse.
REQ-016 The module SHALL have port idone, input, 1 bit: one-cycle completion pulse from the draw engine.
REQ-017 The module SHALL have port obusy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-018 The module SHALL have port oframe_done, output, 1 bit: one-cycle pulse after the last sprite is drawn.
REQ-019 The module SHALL have port oovr, output, 1 bit: sticky tick-overrun flag.

Function
REQ-020 The tick counter SHALL count 0..TICK_MAX and wrap; the tick is asserted in the cycle the count equals TICK_MAX.
REQ-021 On a tick with ienable=1 in IDLE, every sprite SHALL latch old<=cur and cur<=next, and the FSM SHALL enter ERASE_REQ with index 0.
REQ-022 In raster mode, next SHALL be x+1; at X_MAX it SHALL be x=0 and y+1; at (X_MAX,Y_MAX) it SHALL be (0,0).
REQ-023 The FSM states SHALL be IDLE, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT and FRAME_END.
REQ-024 In ERASE_REQ, the module SHALL drive ovld=1 for one cycle with old[k] and BG_COLOR, then go to ERASE_WAIT.
REQ-025 On idone in ERASE_WAIT, the module SHALL go to ERASE_REQ for k+1; after k=N_SPR-1 it SHALL go to DRAW_REQ with k=0.
REQ-026 DRAW_REQ and DRAW_WAIT SHALL work the same way, using cur[k] and icolor slice k; after the last sprite the FSM SHALL go to FRAME_END.
REQ-027 FRAME_END SHALL pulse oframe_done for one cycle and then return to IDLE.
REQ-028 ovld SHALL rise exactly one cycle after the accepting tick.
REQ-029 idone SHALL be ignored in every state other than ERASE_WAIT and DRAW_WAIT.
REQ-030 ox, oy and ocolor SHALL hold stable from ovld until idone.
REQ-031 A tick arriving while obusy=1 SHALL be dropped, positions SHALL NOT change, and oovr SHALL be set.
REQ-032 A tick with ienable=0 SHALL be ignored without setting oovr.
REQ-033 Erase-all-then-draw-all ordering SHALL ensure overlapping sprites are never erased after being drawn.

Reset
REQ-034 On rst, the counter, k, ovld, oframe_done and oovr SHALL clear to 0, and the FSM SHALL go to IDLE.
REQ-035 On rst, sprite k SHALL reset to cur=old=(k,0), and all direction bits SHALL reset to +1.
REQ-036 rst asserted mid-sequence SHALL abort the sequence immediately, with no further ovld until the next accepted tick.

Configuration
REQ-037 Macro SPIXEL_ANIMATOR_BOUNCE_EN defined SHALL add per-sprite dx/dy direction bits.
REQ-038 With that macro, next SHALL be x+dx, y+dy; at x=0 or x=X_MAX, dx SHALL negate before the step, and dy likewise at the y edges.
REQ-039 Without that macro, only raster mode SHALL exist and no direction registers SHALL be built.

Structure
REQ-040 The state enum, the position struct {x,y} and the reset-position function SHALL reside in package spixel_pkg.
REQ-041 Next-position arithmetic SHALL reside in sub-module spixel_stepper, one instance per sprite.

Verification
REQ-042 TICK_MAX=9, N_SPR=2, idone returned 3 cycles after each ovld -> ovld sequence erase (0,0),(1,0) FF, then draw (1,0),(2,0); oframe_done one cycle after the last idone.
REQ-043 Sprite at (31,0), tick -> cur=(0,1); sprite at (31,23), tick -> cur=(0,0).
REQ-044 idone withheld for 25 cycles with TICK_MAX=9 -> oovr=1, positions unchanged, and ox/oy held stable.
REQ-045 rst pulsed during DRAW_WAIT -> next cycle obusy=0, ovld=0, oovr=0, and cur=(k,0).
REQ-046 With BOUNCE_EN, sprite at (31,5) with dx=+1, dy=+1, tick -> cur=(30,6) and dx=-1.
REQ-047 ienable=0 across 3 ticks -> no ovld and oovr=0.
